iiitb_rtc_alarm: RTL and testbench

//  Downstream consumer of the RTC BCD time digits. Holds a programmable HH:MM alarm and compares it

---
 rtl/iiitb_rtc_alarm_pkg.sv | 24 ++
 rtl/iiitb_rtc_alarm_if.sv | 30 +++
 rtl/iiitb_rtc_alarm_timer.sv | 24 ++
 rtl/iiitb_rtc_alarm.sv | 137 +++++++++++++
 tb/tb_iiitb_rtc_alarm.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/iiitb_rtc_alarm_pkg.sv
// Shared definitions for the RTC alarm slice: BCD digit limits, FSM encodings
// and the alarm-write validity check.
package iiitb_rtc_alarm_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] MAX_UNITS     = 4'd9;
  localparam logic [BCD_W-1:0] MAX_TENS_MIN  = 4'd5;
  localparam logic [BCD_W-1:0] MAX_TENS_HR   = 4'd2;
  localparam logic [BCD_W-1:0] MAX_UNITS_HR2 = 4'd3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_RINGING  = 2'd2;
  localparam logic [1:0] ST_SNOOZING = 2'd3;

  // An alarm value is a legal 24-hour HH:MM in BCD.
  function automatic logic alm_valid(input logic [BCD_W-1:0] hm, input logic [BCD_W-1:0] hl,
                                     input logic [BCD_W-1:0] mm, input logic [BCD_W-1:0] ml);
    return (hm <= MAX_TENS_HR) && (hl <= MAX_UNITS) && (mm <= MAX_TENS_MIN) &&
           (ml <= MAX_UNITS) && !((hm == MAX_TENS_HR) && (hl > MAX_UNITS_HR2));
  endfunction

endpackage

// File: rtl/iiitb_rtc_alarm_if.sv
// Signal bundle between the RTC time source / user controls and the alarm block.
// alm_wr, snooze and dismiss are single-cycle strobes sampled on every hundred_clk
// edge; there is no ready: the alarm always accepts them in the cycle they are high.
interface iiitb_rtc_alarm_if;
  import iiitb_rtc_alarm_pkg::*;

  logic [BCD_W-1:0] hrm, hrl, minm, minl, secm, secl;
  logic             alm_en;
  logic             alm_wr;
  logic [BCD_W-1:0] alm_hrm, alm_hrl, alm_minm, alm_minl;
  logic             snooze;
  logic             dismiss;
  logic             ring;
  logic             armed;
  logic [1:0]       alm_state;
  logic             wr_err;
  logic [1:0]       snz_left;

  modport master (
    output hrm, hrl, minm, minl, secm, secl,
    output alm_en, alm_wr, alm_hrm, alm_hrl, alm_minm, alm_minl, snooze, dismiss,
    input  ring, armed, alm_state, wr_err, snz_left
  );

  modport slave (
    input  hrm, hrl, minm, minl, secm, secl,
    input  alm_en, alm_wr, alm_hrm, alm_hrl, alm_minm, alm_minl, snooze, dismiss,
    output ring, armed, alm_state, wr_err, snz_left
  );
endinterface

// File: rtl/iiitb_rtc_alarm_timer.sv
// Loadable down-counter that saturates at zero; used for ring and snooze durations.
module alarm_timer #(
  parameter int WIDTH = 6
) (
  input  logic             hundred_clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] val,
  input  logic             dec,
  output logic             zero
);
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge hundred_clk) begin
    if (!rst)
      cnt <= '0;
    else if (load)
      cnt <= val;
    else if (dec && (cnt != '0))
      cnt <= cnt - WIDTH'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/iiitb_rtc_alarm.sv
// HH:MM alarm on live BCD RTC time with ring timeout, limited snooze and dismiss.
// One hundred_clk cycle is one RTC second.
module iiitb_rtc_alarm
  import iiitb_rtc_alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input logic               hundred_clk,
  input logic               rst,
  iiitb_rtc_alarm_if.slave  bus
);
  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = $clog2(SNOOZE_SECS + 1);
  localparam logic [RW-1:0] RING_LOAD = RW'(RING_SECS - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SECS - 1);
  localparam logic [1:0]    SNZ_MAX   = 2'(MAX_SNOOZE);

  logic [BCD_W-1:0] a_hrm, a_hrl, a_minm, a_minl;
  logic [1:0]       state, next_state;
  logic [1:0]       snz_left, snz_left_nxt;
  logic             ring, wr_err;
  logic             wr_ok, match;
  logic             ring_ld, ring_dec, ring_zero;
  logic             snz_ld, snz_dec, snz_zero;
  logic [RW-1:0]    ring_val;
  logic [SW-1:0]    snz_val;

  assign wr_ok = bus.alm_wr && alm_valid(bus.alm_hrm, bus.alm_hrl, bus.alm_minm, bus.alm_minl);
  assign match = (bus.hrm == a_hrm) && (bus.hrl == a_hrl) && (bus.minm == a_minm) &&
                 (bus.minl == a_minl) && (bus.secm == '0) && (bus.secl == '0);

  always_comb begin
    next_state   = state;
    snz_left_nxt = snz_left;
    ring_ld      = 1'b0;
    ring_val     = RING_LOAD;
    ring_dec     = 1'b0;
    snz_ld       = 1'b0;
    snz_val      = SNZ_LOAD;
    snz_dec      = 1'b0;
    if (!bus.alm_en) begin
      next_state   = ST_IDLE;
      snz_left_nxt = SNZ_MAX;
      ring_ld      = 1'b1;
      ring_val     = '0;
      snz_ld       = 1'b1;
      snz_val      = '0;
    end else if (wr_ok) begin
      next_state = ST_ARMED;
    end else begin
      case (state)
        ST_IDLE: next_state = ST_ARMED;
        ST_ARMED: begin
          if (match) begin
            next_state   = ST_RINGING;
            ring_ld      = 1'b1;
            snz_left_nxt = SNZ_MAX;
          end
        end
        ST_RINGING: begin
          // Dismiss outranks snooze when both strobes land together.
          if (bus.dismiss) begin
            next_state = ST_ARMED;
          end else if (bus.snooze && (snz_left != 2'd0)) begin
            next_state   = ST_SNOOZING;
            snz_ld       = 1'b1;
            snz_left_nxt = snz_left - 2'd1;
          end else if (ring_zero) begin
            next_state = ST_ARMED;
          end else begin
            ring_dec = 1'b1;
          end
        end
        default: begin
          if (bus.dismiss) begin
            next_state = ST_ARMED;
          end else if (snz_zero) begin
            next_state = ST_RINGING;
            ring_ld    = 1'b1;
          end else begin
            snz_dec = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge hundred_clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ring     <= 1'b0;
      wr_err   <= 1'b0;
      snz_left <= SNZ_MAX;
      a_hrm    <= '0;
      a_hrl    <= '0;
      a_minm   <= '0;
      a_minl   <= '0;
    end else begin
      state    <= next_state;
      ring     <= (next_state == ST_RINGING);
      wr_err   <= bus.alm_wr && !wr_ok;
      snz_left <= snz_left_nxt;
      if (wr_ok) begin
        a_hrm  <= bus.alm_hrm;
        a_hrl  <= bus.alm_hrl;
        a_minm <= bus.alm_minm;
        a_minl <= bus.alm_minl;
      end
    end
  end

  alarm_timer #(.WIDTH(RW)) u_ring_timer (
    .hundred_clk (hundred_clk),
    .rst         (rst),
    .load        (ring_ld),
    .val         (ring_val),
    .dec         (ring_dec),
    .zero        (ring_zero)
  );

  alarm_timer #(.WIDTH(SW)) u_snz_timer (
    .hundred_clk (hundred_clk),
    .rst         (rst),
    .load        (snz_ld),
    .val         (snz_val),
    .dec         (snz_dec),
    .zero        (snz_zero)
  );

  assign bus.ring      = ring;
  assign bus.armed     = (state != ST_IDLE);
  assign bus.alm_state = state;
  assign bus.wr_err    = wr_err;
  assign bus.snz_left  = snz_left;
endmodule

// File: tb/tb_iiitb_rtc_alarm.sv
// Directed bench for iiitb_rtc_alarm: the bench owns a seconds-of-day clock that it
// drives as BCD digits, then steps through alarm, snooze, dismiss and reset scenarios.
module tb_iiitb_rtc_alarm;
  import iiitb_rtc_alarm_pkg::*;

  logic hundred_clk;
  logic rst;
  iiitb_rtc_alarm_if bus();

  int checks = 0;
  int errors = 0;
  int tod    = 0;
  int n;
  logic [31:0] exp_q[$];

  iiitb_rtc_alarm dut (
    .hundred_clk (hundred_clk),
    .rst         (rst),
    .bus         (bus)
  );

  // clock / reset
  initial hundred_clk = 1'b0;
  always #5 hundred_clk = ~hundred_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive_time();
    bus.hrm  = 4'((tod / 3600) / 10);
    bus.hrl  = 4'((tod / 3600) % 10);
    bus.minm = 4'(((tod / 60) % 60) / 10);
    bus.minl = 4'(((tod / 60) % 60) % 10);
    bus.secm = 4'((tod % 60) / 10);
    bus.secl = 4'((tod % 60) % 10);
  endtask

  task automatic set_time(input int t);
    tod = t;
    drive_time();
  endtask

  task automatic tick();
    @(posedge hundred_clk);
    #1;
    tod = (tod + 1) % 86400;
    drive_time();
  endtask

  task automatic do_write(input logic [3:0] hm, input logic [3:0] hl,
                          input logic [3:0] mm, input logic [3:0] ml);
    bus.alm_wr = 1'b1;
    bus.alm_hrm = hm; bus.alm_hrl = hl; bus.alm_minm = mm; bus.alm_minl = ml;
    tick();
    bus.alm_wr = 1'b0;
  endtask

  task automatic pulse(input logic snz, input logic dis);
    bus.snooze = snz;
    bus.dismiss = dis;
    tick();
    bus.snooze = 1'b0;
    bus.dismiss = 1'b0;
  endtask

  task automatic wait_ring(input int bound, output int cnt);
    cnt = 0;
    while (!bus.ring && cnt < bound) begin
      tick();
      cnt++;
    end
  endtask

  task automatic count_ring(input int bound, output int cnt);
    cnt = 0;
    while (bus.ring && cnt < bound) begin
      cnt++;
      tick();
    end
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.alm_en = 1'b0; bus.alm_wr = 1'b0; bus.snooze = 1'b0; bus.dismiss = 1'b0;
    bus.alm_hrm = '0; bus.alm_hrl = '0; bus.alm_minm = '0; bus.alm_minl = '0;
    exp_q = '{32'd2, 32'd1, 32'd0};
    set_time(0);
    tick();
    tick();
    check("rst_state", bus.alm_state, ST_IDLE);
    check("rst_ring", bus.ring, 0);
    check("rst_armed", bus.armed, 0);
    check("rst_wr_err", bus.wr_err, 0);
    check("rst_snz_left", bus.snz_left, 3);

    // 00:00:00 right after reset must arm, not ring
    rst = 1'b1;
    bus.alm_en = 1'b1;
    set_time(0);
    tick();
    check("post_rst_state", bus.alm_state, ST_ARMED);
    check("post_rst_ring", bus.ring, 0);

    // alarm 00:02, clock from 00:00:02
    do_write(4'd0, 4'd0, 4'd0, 4'd2);
    check("wr_ok_no_err", bus.wr_err, 0);
    wait_ring(200, n);
    check("ring_0002_delay", n, 119);
    check("ring_0002_state", bus.alm_state, ST_RINGING);
    count_ring(200, n);
    check("ring_0002_len", n, 60);
    check("ring_0002_after", bus.alm_state, ST_ARMED);

    // 07:30 with snoozes
    do_write(4'd0, 4'd7, 4'd3, 4'd0);
    set_time(7 * 3600 + 30 * 60 - 2);
    wait_ring(10, n);
    check("ring_0730_delay", n, 3);
    check("snz_left_init", bus.snz_left, 3);
    for (int i = 0; i < 4; i++) tick();
    check("ring_cycle5", bus.ring, 1);
    for (int k = 0; k < 3; k++) begin
      pulse(1'b1, 1'b0);
      check("snooze_state", bus.alm_state, ST_SNOOZING);
      check("snooze_ring", bus.ring, 0);
      check("snooze_left", bus.snz_left, exp_q.pop_front());
      wait_ring(400, n);
      check("snooze_gap", n, 300);
    end
    pulse(1'b1, 1'b0);
    check("snooze4_state", bus.alm_state, ST_RINGING);
    check("snooze4_left", bus.snz_left, 0);
    count_ring(100, n);
    check("snooze4_tail", n, 59);
    check("snooze4_after", bus.alm_state, ST_ARMED);

    // rejected writes keep 07:30
    do_write(4'd2, 4'd4, 4'd0, 4'd0);
    check("wr_err_2400", bus.wr_err, 1);
    tick();
    check("wr_err_clear", bus.wr_err, 0);
    do_write(4'd1, 4'd2, 4'd6, 4'd10);
    check("wr_err_126a", bus.wr_err, 1);
    check("wr_err_state", bus.alm_state, ST_ARMED);
    set_time(86398);
    wait_ring(5, n);
    check("no_ring_midnight", n, 5);
    set_time(7 * 3600 + 30 * 60 - 1);
    wait_ring(10, n);
    check("regs_kept_0730", n, 2);
    pulse(1'b0, 1'b1);
    check("dismiss_state", bus.alm_state, ST_ARMED);
    check("dismiss_ring", bus.ring, 0);

    // alarm 00:00 across the midnight wrap
    do_write(4'd2, 4'd3, 4'd5, 4'd9);
    check("wr_2359_ok", bus.wr_err, 0);
    do_write(4'd0, 4'd0, 4'd0, 4'd0);
    set_time(86398);
    wait_ring(10, n);
    check("ring_wrap_delay", n, 3);
    pulse(1'b1, 1'b1);
    check("dis_snz_state", bus.alm_state, ST_ARMED);
    check("dis_snz_ring", bus.ring, 0);
    check("dis_snz_left", bus.snz_left, 3);

    // disable while ringing
    set_time(86399);
    wait_ring(10, n);
    check("ring_again", n, 2);
    bus.alm_en = 1'b0;
    tick();
    check("dis_en_state", bus.alm_state, ST_IDLE);
    check("dis_en_ring", bus.ring, 0);
    check("dis_en_armed", bus.armed, 0);
    bus.alm_en = 1'b1;
    tick();
    check("re_en_state", bus.alm_state, ST_ARMED);

    // reset while snoozing
    set_time(86399);
    wait_ring(10, n);
    check("ring_pre_rst", n, 2);
    pulse(1'b1, 1'b0);
    check("snz_pre_rst", bus.alm_state, ST_SNOOZING);
    rst = 1'b0;
    tick();
    check("mid_rst_state", bus.alm_state, ST_IDLE);
    check("mid_rst_ring", bus.ring, 0);
    check("mid_rst_armed", bus.armed, 0);
    check("mid_rst_left", bus.snz_left, 3);
    rst = 1'b1;
    wait_ring(400, n);
    check("no_rering_after_rst", n, 400);

    // new value written while ringing
    set_time(86399);
    wait_ring(10, n);
    check("ring_pre_wr", n, 2);
    do_write(4'd0, 4'd0, 4'd0, 4'd5);
    check("wr_ringing_state", bus.alm_state, ST_ARMED);
    check("wr_ringing_ring", bus.ring, 0);
    set_time(86399);
    wait_ring(5, n);
    check("old_time_silent", n, 5);
    set_time(4 * 60 + 59);
    wait_ring(10, n);
    check("new_time_rings", n, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
